trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Sequences machine-mode trap entry and return against the CSR block. Accepts synchronous exceptions, pre-qualified interrupt requests and MRET from the core, arbitrates them, and drives the CSR `available`/`busy` handshake. It then returns the redirect PC (handler address or saved `mepc`) to the fetch stage as a one-cycle pulse. It sits between the core control path and the CSR block, and is the only master of the CSR exception/MRET ops.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum cycles in ISSUE+WAIT before the CSR is declared hung. Range 2..255.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset. Only one clock domain.
- `exc_valid` in 1: one-cycle exception pulse.
- `exc_code` in 4: exception cause code.
- `exc_pc` in 32: PC of the faulting instruction.
- `mret_valid` in 1: one-cycle MRET pulse.
- `irq_ext` in 1: external interrupt request, level, already masked by the core.
- `irq_sw` in 1: software interrupt request, level, already masked.
- `next_pc` in 32: PC to resume at after an interrupt.
- `csr_available`, `csr_op[2:0]`, `csr_addr_exception[11:0]`, `csr_write_value[31:0]` out: CSR request.
- `csr_read_value` in 32, `csr_busy` in 1, `csr_fault` in 1: CSR response.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: target PC, valid with `redirect_valid`.
- `trap_busy` out 1: high from the cycle after accept until return to IDLE.
- `fatal` out 1: sticky CSR-fault or timeout indication.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, HALT.
- IDLE: requests are sampled only in IDLE. Priority: `exc_valid` > `irq_ext` > `irq_sw` > `mret_valid`; lower-priority pulses in the same cycle are dropped. On accept, register the request and go to ISSUE.
  - Exception: op 3'b000, addr = {7'b0, 1'b0, `exc_code`}, write_value = `exc_pc`.
  - External interrupt: op 3'b000, addr = 12'h01B (interrupt bit 4 set, code 11), write_value = `next_pc`.
  - Software interrupt: op 3'b000, addr = 12'h013 (code 3), write_value = `next_pc`.
  - MRET: op 3'b001, addr 0, write_value 0.
- ISSUE: `csr_available`=1, operands held stable. Go to WAIT on `csr_busy`=1.
- WAIT: `csr_available`=1. On `csr_busy`=0, capture `csr_read_value` and `csr_fault`, drop `csr_available`, then:
  - no fault → pulse `redirect_valid` with `redirect_pc` = captured value, go to RELEASE;
  - fault → set `fatal`, go to HALT, no redirect.
- RELEASE: `csr_available`=0 for one cycle so the CSR returns to idle, then go to IDLE.
- Timeout counter (8-bit): cleared on accept, increments each cycle in ISSUE/WAIT. When it reaches `TIMEOUT_CYCLES`, set `fatal`, drop `csr_available`, go to HALT.
- HALT: absorbing state. `trap_busy`=1, `csr_available`=0; all requests are ignored until reset.
- Reset (any time, including mid-handshake): state IDLE, all outputs 0, counter 0, `fatal` 0.

## Timing
- All outputs are registered.
- Accept in cycle 0 → `csr_available`=1 and `trap_busy`=1 in cycle 1.
- With a single-cycle CSR: `csr_busy` high in cycle 2, low with result in cycle 3. `redirect_valid` pulses in cycle 4 (state RELEASE); IDLE in cycle 5.
- Back-to-back: the next accept is possible in cycle 5.
- `trap_busy` falls in the cycle the state returns to IDLE. The core must not pulse `exc_valid`/`mret_valid` while `trap_busy`=1; such pulses are ignored. Interrupt levels held during busy are taken on the next IDLE cycle.
- `csr_fault` is sampled only on the WAIT→done cycle.

## Structure
- Package `trap_pkg`:
  - state enum;
  - CSR op constants `CSR_OP_EXCEPTION`=3'b000 and `CSR_OP_MRET`=3'b001;
  - cause constants `CAUSE_IRQ_EXT`=4'd11, `CAUSE_IRQ_SW`=4'd3, and the interrupt bit index 4.
- Single module, no sub-module. The priority encoder is a combinational block inside.

## Test plan
- Exception: `exc_valid`, `exc_code`=2, `exc_pc`=32'h0000_0100 → CSR sees op 000, addr 12'h002, wv 32'h100. `redirect_valid` in cycle 4 with `redirect_pc`=32'h10 (default handler); `trap_busy` low in cycle 5.
- Exception then MRET: `exc_pc`=32'h200, then `mret_valid` → second redirect `redirect_pc`=32'h200.
- Simultaneous `exc_valid`, `irq_ext`, `mret_valid` → exactly one CSR op, addr 12'h00x with bit 4=0; MRET is dropped. `irq_ext` still held afterwards → taken next, addr 12'h01B, wv=`next_pc`.
- CSR model holds `csr_busy` high forever → `fatal`=1 after 15 cycles in ISSUE/WAIT; `csr_available`=0; no `redirect_valid`; later requests ignored.
- CSR model returns `csr_fault`=1 → `fatal`=1, HALT, no redirect.
- Reset asserted in WAIT → `csr_available` and `trap_busy` go low asynchronously. After release, a fresh exception completes with normal cycle-4 latency.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_HALT    = 3'd4
  } trap_state_t;

  // CSR block operations mastered by the sequencer.
  localparam logic [2:0] CSR_OP_EXCEPTION = 3'b000;
  localparam logic [2:0] CSR_OP_MRET      = 3'b001;

  // Interrupt cause codes and the address bit that marks a cause as an interrupt.
  localparam logic [3:0] CAUSE_IRQ_EXT = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_SW  = 4'd3;
  localparam int         CAUSE_IRQ_BIT = 4;

  // One complete CSR request as held on the bus for the whole handshake.
  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] write_value;
  } csr_req_t;

  // Cause address: low nibble is the cause code, CAUSE_IRQ_BIT flags interrupts.
  function automatic logic [11:0] cause_addr(input logic is_irq, input logic [3:0] code);
    logic [11:0] addr;
    addr                = {8'h00, code};
    addr[CAUSE_IRQ_BIT] = is_irq;
    return addr;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// CSR request/response bus between the trap sequencer (master) and the CSR block (slave).
interface trap_sequencer_if;

  logic        csr_available;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_busy;
  logic        csr_fault;

  modport master (
    output csr_available,
    output csr_op,
    output csr_addr_exception,
    output csr_write_value,
    input  csr_read_value,
    input  csr_busy,
    input  csr_fault
  );

  modport slave (
    input  csr_available,
    input  csr_op,
    input  csr_addr_exception,
    input  csr_write_value,
    output csr_read_value,
    output csr_busy,
    output csr_fault
  );

endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET,
// runs the CSR available/busy handshake and returns the redirect PC.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exc_valid,
  input  logic [3:0]       exc_code,
  input  logic [31:0]      exc_pc,
  input  logic             mret_valid,
  input  logic             irq_ext,
  input  logic             irq_sw,
  input  logic [31:0]      next_pc,
  trap_sequencer_if.master csr,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             trap_busy,
  output logic             fatal
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  trap_state_t state_reg;
  logic [7:0]  timeout_cnt_reg;
  logic [7:0]  timeout_cnt_next;
  logic        timeout_hit;
  csr_req_t    req_reg;
  logic        avail_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;
  logic        trap_busy_reg;
  logic        fatal_reg;

  logic        accept;
  csr_req_t    accept_req;

  // Fixed-priority request encoder: exception > external irq > software irq > MRET.
  always_comb begin
    accept     = 1'b0;
    accept_req = '0;
    if (exc_valid) begin
      accept                 = 1'b1;
      accept_req.op          = CSR_OP_EXCEPTION;
      accept_req.addr        = cause_addr(1'b0, exc_code);
      accept_req.write_value = exc_pc;
    end else if (irq_ext) begin
      accept                 = 1'b1;
      accept_req.op          = CSR_OP_EXCEPTION;
      accept_req.addr        = cause_addr(1'b1, CAUSE_IRQ_EXT);
      accept_req.write_value = next_pc;
    end else if (irq_sw) begin
      accept                 = 1'b1;
      accept_req.op          = CSR_OP_EXCEPTION;
      accept_req.addr        = cause_addr(1'b1, CAUSE_IRQ_SW);
      accept_req.write_value = next_pc;
    end else if (mret_valid) begin
      accept                 = 1'b1;
      accept_req.op          = CSR_OP_MRET;
      accept_req.addr        = '0;
      accept_req.write_value = '0;
    end
  end

  // The count includes the cycle being finished, so the limit trips after
  // exactly TIMEOUT_CYCLES cycles spent in ISSUE+WAIT.
  assign timeout_cnt_next = timeout_cnt_reg + 8'd1;
  assign timeout_hit      = (timeout_cnt_next >= TIMEOUT_LIMIT);

  // Trap FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      timeout_cnt_reg    <= '0;
      req_reg            <= '0;
      avail_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      trap_busy_reg      <= 1'b0;
      fatal_reg          <= 1'b0;
    end else begin
      redirect_valid_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_reg         <= accept_req;
            timeout_cnt_reg <= '0;
            avail_reg       <= 1'b1;
            trap_busy_reg   <= 1'b1;
            state_reg       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timeout_cnt_reg <= timeout_cnt_next;
          if (timeout_hit) begin
            fatal_reg <= 1'b1;
            avail_reg <= 1'b0;
            state_reg <= ST_HALT;
          end else if (csr.csr_busy) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timeout_cnt_reg <= timeout_cnt_next;
          // A response arriving on the last allowed cycle still wins over the timeout.
          if (!csr.csr_busy) begin
            avail_reg <= 1'b0;
            if (csr.csr_fault) begin
              fatal_reg <= 1'b1;
              state_reg <= ST_HALT;
            end else begin
              redirect_valid_reg <= 1'b1;
              redirect_pc_reg    <= csr.csr_read_value;
              state_reg          <= ST_RELEASE;
            end
          end else if (timeout_hit) begin
            fatal_reg <= 1'b1;
            avail_reg <= 1'b0;
            state_reg <= ST_HALT;
          end
        end
        ST_RELEASE: begin
          trap_busy_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        ST_HALT: begin
          avail_reg     <= 1'b0;
          trap_busy_reg <= 1'b1;
        end
        default: begin
          // Corrupted state encoding is treated like a hung CSR.
          fatal_reg     <= 1'b1;
          avail_reg     <= 1'b0;
          trap_busy_reg <= 1'b1;
          state_reg     <= ST_HALT;
        end
      endcase
    end
  end

  assign csr.csr_available      = avail_reg;
  assign csr.csr_op             = req_reg.op;
  assign csr.csr_addr_exception = req_reg.addr;
  assign csr.csr_write_value    = req_reg.write_value;

  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign trap_busy      = trap_busy_reg;
  assign fatal          = fatal_reg;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed + randomized bench for trap_sequencer with a behavioural CSR block.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam logic [31:0] MTVEC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        mret_valid = 1'b0;
  logic        irq_ext = 1'b0;
  logic        irq_sw = 1'b0;
  logic [31:0] next_pc = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_busy;
  logic        fatal;

  trap_sequencer_if csr_bus ();

  trap_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .mret_valid     (mret_valid),
    .irq_ext        (irq_ext),
    .irq_sw         (irq_sw),
    .next_pc        (next_pc),
    .csr            (csr_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_busy      (trap_busy),
    .fatal          (fatal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int redirect_count = 0;
  logic [31:0] ref_mepc = '0;

  // CSR block model controls
  int   csr_extra = 0;
  logic csr_stuck = 1'b0;
  logic csr_fault_mode = 1'b0;

  // Behavioural CSR block: busy one cycle after available, result after csr_extra more.
  int          m_phase;
  int          m_lat;
  logic [31:0] m_mepc = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase                <= 0;
      m_lat                  <= 0;
      csr_bus.csr_busy       <= 1'b0;
      csr_bus.csr_fault      <= 1'b0;
      csr_bus.csr_read_value <= '0;
    end else begin
      case (m_phase)
        0: if (csr_bus.csr_available) begin
          csr_bus.csr_busy <= 1'b1;
          m_lat            <= csr_extra;
          m_phase          <= 1;
        end
        1: if (!csr_stuck) begin
          if (m_lat == 0) begin
            csr_bus.csr_busy  <= 1'b0;
            csr_bus.csr_fault <= csr_fault_mode;
            if (csr_bus.csr_op == CSR_OP_MRET) begin
              csr_bus.csr_read_value <= m_mepc;
            end else begin
              csr_bus.csr_read_value <= MTVEC;
              m_mepc                 <= csr_bus.csr_write_value;
            end
            m_phase <= 2;
          end else begin
            m_lat <= m_lat - 1;
          end
        end
        default: if (!csr_bus.csr_available) begin
          csr_bus.csr_fault <= 1'b0;
          m_phase           <= 0;
        end
      endcase
    end
  end

  // Count every redirect pulse the DUT emits.
  always @(posedge clk) begin
    if (redirect_valid === 1'b1) redirect_count <= redirect_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Request inputs must already be driven in the current (IDLE) cycle = cycle 0.
  task automatic run_txn(input string name, input logic [2:0] e_op, input logic [11:0] e_addr,
                         input logic [31:0] e_wv, input logic [31:0] e_pc, input int extra,
                         input bit drop_irq);
    int rc0;
    rc0       = redirect_count;
    csr_extra = extra;
    step();  // cycle 1
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    if (drop_irq) begin
      irq_ext = 1'b0;
      irq_sw  = 1'b0;
    end
    chk({name, ":avail_c1"}, 32'(csr_bus.csr_available), 32'd1);
    chk({name, ":busy_c1"}, 32'(trap_busy), 32'd1);
    chk({name, ":op"}, 32'(csr_bus.csr_op), 32'(e_op));
    chk({name, ":addr"}, 32'(csr_bus.csr_addr_exception), 32'(e_addr));
    chk({name, ":wv"}, csr_bus.csr_write_value, e_wv);
    step();  // cycle 2: pulses while busy must be ignored
    exc_valid  = 1'b1;
    exc_code   = 4'hF;
    exc_pc     = 32'hDEAD_BEEF;
    mret_valid = 1'b1;
    step();  // cycle 3
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    chk({name, ":addr_held"}, 32'(csr_bus.csr_addr_exception), 32'(e_addr));
    chk({name, ":wv_held"}, csr_bus.csr_write_value, e_wv);
    repeat (extra) step();
    chk({name, ":no_early_redirect"}, 32'(redirect_valid), 32'd0);
    step();  // cycle 4 + extra
    chk({name, ":redirect_valid"}, 32'(redirect_valid), 32'd1);
    chk({name, ":redirect_pc"}, redirect_pc, e_pc);
    chk({name, ":avail_dropped"}, 32'(csr_bus.csr_available), 32'd0);
    step();  // cycle 5 + extra
    chk({name, ":busy_low"}, 32'(trap_busy), 32'd0);
    chk({name, ":pulse_one_cycle"}, 32'(redirect_valid), 32'd0);
    chk({name, ":redirect_count"}, 32'(redirect_count - rc0), 32'd1);
    $display("txn %s op=%0d addr=%03h wv=%08h redirect_pc=%08h lat=%0d",
             name, e_op, e_addr, e_wv, e_pc, extra);
  endtask

  initial begin
    int rc0;
    logic [3:0] r;
    logic [2:0] e_op;
    logic [11:0] e_addr;
    logic [31:0] e_wv;
    logic [31:0] e_pc;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst:avail", 32'(csr_bus.csr_available), 32'd0);
    chk("rst:busy", 32'(trap_busy), 32'd0);
    chk("rst:fatal", 32'(fatal), 32'd0);
    chk("rst:redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst:redirect_pc", redirect_pc, 32'd0);
    chk("rst:addr", 32'(csr_bus.csr_addr_exception), 32'd0);
    step();
    reset = 1'b0;
    step();
    $display("txn reset done");

    // Exception code 2 at 0x100.
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h0000_0100;
    run_txn("exc2", 3'b000, 12'h002, 32'h100, MTVEC, 0, 1'b1);
    ref_mepc = 32'h100;

    // Exception then MRET returns to the faulting PC.
    exc_valid = 1'b1; exc_code = 4'd6; exc_pc = 32'h0000_0200;
    run_txn("exc6", 3'b000, 12'h006, 32'h200, MTVEC, 1, 1'b1);
    ref_mepc = 32'h200;
    mret_valid = 1'b1;
    run_txn("mret", 3'b001, 12'h000, 32'h0, 32'h200, 0, 1'b1);

    // Simultaneous exception, external irq and MRET; irq held stays pending.
    exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h0000_0300;
    irq_ext = 1'b1; mret_valid = 1'b1; next_pc = 32'h0000_0800;
    run_txn("simul_exc", 3'b000, 12'h005, 32'h300, MTVEC, 0, 1'b0);
    ref_mepc = 32'h300;
    run_txn("held_irq_ext", 3'b000, 12'h01B, 32'h800, MTVEC, 0, 1'b1);
    ref_mepc = 32'h800;
    repeat (3) step();
    chk("simul:mret_dropped", 32'(csr_bus.csr_available), 32'd0);
    chk("simul:idle", 32'(trap_busy), 32'd0);

    // Randomized requests against the priority rules.
    for (int t = 0; t < 40; t++) begin
      r        = 4'($urandom_range(1, 15));
      exc_code = 4'($urandom);
      exc_pc   = $urandom;
      next_pc  = $urandom;
      exc_valid = r[0]; irq_ext = r[1]; irq_sw = r[2]; mret_valid = r[3];
      if (r[0]) begin
        e_op = 3'b000; e_addr = {8'h00, exc_code}; e_wv = exc_pc; e_pc = MTVEC;
      end else if (r[1]) begin
        e_op = 3'b000; e_addr = 12'h01B; e_wv = next_pc; e_pc = MTVEC;
      end else if (r[2]) begin
        e_op = 3'b000; e_addr = 12'h013; e_wv = next_pc; e_pc = MTVEC;
      end else begin
        e_op = 3'b001; e_addr = 12'h000; e_wv = 32'h0; e_pc = ref_mepc;
      end
      run_txn($sformatf("rnd%0d", t), e_op, e_addr, e_wv, e_pc, int'($urandom_range(0, 3)), 1'b1);
      if (e_op == 3'b000) ref_mepc = e_wv;
    end

    // Reset while in WAIT, then a normal exception.
    csr_extra = 3;
    exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 32'h0000_0400;
    step();
    exc_valid = 1'b0;
    step();
    step();  // cycle 3, WAIT
    chk("rstwait:pre_avail", 32'(csr_bus.csr_available), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstwait:avail", 32'(csr_bus.csr_available), 32'd0);
    chk("rstwait:busy", 32'(trap_busy), 32'd0);
    step();
    step();
    reset = 1'b0;
    $display("txn reset in WAIT");
    exc_valid = 1'b1; exc_code = 4'd7; exc_pc = 32'h0000_0500;
    run_txn("post_rst_exc", 3'b000, 12'h007, 32'h500, MTVEC, 0, 1'b1);
    ref_mepc = 32'h500;

    // CSR fault: fatal, HALT, no redirect.
    csr_fault_mode = 1'b1;
    csr_extra = 0;
    rc0 = redirect_count;
    exc_valid = 1'b1; exc_code = 4'd4; exc_pc = 32'h0000_0600;
    step();
    exc_valid = 1'b0;
    step();
    step();
    chk("fault:fatal_c3", 32'(fatal), 32'd0);
    step();  // cycle 4
    chk("fault:fatal", 32'(fatal), 32'd1);
    chk("fault:avail", 32'(csr_bus.csr_available), 32'd0);
    chk("fault:busy", 32'(trap_busy), 32'd1);
    chk("fault:no_redirect", 32'(redirect_valid), 32'd0);
    csr_fault_mode = 1'b0;
    irq_sw = 1'b1;
    repeat (4) step();
    irq_sw = 1'b0;
    chk("fault:halt_ignores", 32'(csr_bus.csr_available), 32'd0);
    chk("fault:halt_busy", 32'(trap_busy), 32'd1);
    chk("fault:redirects", 32'(redirect_count - rc0), 32'd0);
    $display("txn csr fault -> HALT");
    do_reset();
    chk("fault:fatal_cleared", 32'(fatal), 32'd0);

    // Hung CSR: busy forever, timeout after 15 cycles in ISSUE/WAIT.
    csr_stuck = 1'b1;
    rc0 = redirect_count;
    exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 32'h0000_0700;
    step();  // cycle 1
    exc_valid = 1'b0;
    repeat (14) step();  // cycle 15
    chk("hang:fatal_c15", 32'(fatal), 32'd0);
    chk("hang:avail_c15", 32'(csr_bus.csr_available), 32'd1);
    step();  // cycle 16
    chk("hang:fatal", 32'(fatal), 32'd1);
    chk("hang:avail", 32'(csr_bus.csr_available), 32'd0);
    chk("hang:busy", 32'(trap_busy), 32'd1);
    exc_valid = 1'b1;
    step();
    exc_valid = 1'b0;
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    repeat (3) step();
    chk("hang:ignores", 32'(csr_bus.csr_available), 32'd0);
    chk("hang:no_redirect", 32'(redirect_count - rc0), 32'd0);
    chk("hang:fatal_sticky", 32'(fatal), 32'd1);
    $display("txn hung CSR -> HALT");
    csr_stuck = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
